// File: rtl/sample_streamer_if.sv
// Signal bundle joining sample_streamer to its control source, the channel
// sample RAM and the delay beamformer.
interface sample_streamer_if;
  logic        start;
  logic        abort;
  logic [15:0] ram_address;
  logic        ram_rden;
  logic [31:0] ram_q;
  logic [31:0] sample_value;
  logic [15:0] sample_index;
  logic        startbeamformer;
  logic        busy;
  logic        done;

  modport master (
    input  start,
    input  abort,
    input  ram_q,
    output ram_address,
    output ram_rden,
    output sample_value,
    output sample_index,
    output startbeamformer,
    output busy,
    output done
  );

  modport slave (
    output start,
    output abort,
    output ram_q,
    input  ram_address,
    input  ram_rden,
    input  sample_value,
    input  sample_index,
    input  startbeamformer,
    input  busy,
    input  done
  );
endinterface

// File: rtl/sample_streamer.sv
// Frame source for the delay beamformer: walks the sample RAM in address order
// and presents every word with its index for HOLD_CYCLES cycles.
module sample_streamer #(
  parameter int unsigned NUM_SAMPLES = 4096,
  parameter int unsigned RAM_LATENCY = 2,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  sample_streamer_if.master bus
);

  localparam logic [16:0]         LAST_IDX  = 17'(NUM_SAMPLES - 1);
  localparam int unsigned         LAT_W     = $clog2(RAM_LATENCY + 2);
  localparam int unsigned         HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [LAT_W-1:0]    LAT_LAST  = LAT_W'(RAM_LATENCY);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  if (HOLD_CYCLES < RAM_LATENCY + 1) begin : g_bad_hold
    $error("sample_streamer: HOLD_CYCLES must be at least RAM_LATENCY+1");
  end
  if (NUM_SAMPLES < 1 || NUM_SAMPLES > 65536) begin : g_bad_num
    $error("sample_streamer: NUM_SAMPLES must be within 1..65536");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  state_t              r_state;
  logic [15:0]         r_addr;
  logic                r_rden;
  logic [31:0]         r_value;
  logic [15:0]         r_index;
  logic                r_sbf;
  logic                r_busy;
  logic                r_done;
  logic [LAT_W-1:0]    r_lat;
  logic [HOLD_W-1:0]   r_hold;

  state_t              w_state_nxt;
  logic [15:0]         w_addr_nxt;
  logic                w_rden_nxt;
  logic [31:0]         w_value_nxt;
  logic [15:0]         w_index_nxt;
  logic                w_sbf_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic [LAT_W-1:0]    w_lat_nxt;
  logic [HOLD_W-1:0]   w_hold_nxt;

  logic                w_go;
  logic                w_lat_last;
  logic                w_hold_last;
  logic                w_more;
  logic [15:0]         w_first_addr;
  logic [15:0]         w_next_addr;

  // Read addresses are clamped so the RAM is never addressed past the frame.
  function automatic logic [15:0] clamp_addr(input logic [16:0] a);
    if (a > LAST_IDX) begin
      clamp_addr = LAST_IDX[15:0];
    end else begin
      clamp_addr = a[15:0];
    end
  endfunction

  assign w_go         = bus.start & ~bus.abort;
  assign w_lat_last   = (r_lat == LAT_LAST);
  assign w_hold_last  = (r_hold == HOLD_LAST);
  assign w_more       = ({1'b0, r_index} < LAST_IDX);
  assign w_first_addr = clamp_addr(17'd1);
  assign w_next_addr  = clamp_addr({1'b0, r_index} + 17'd2);

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_rden  <= 1'b0;
      r_value <= '0;
      r_index <= '0;
      r_sbf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_lat   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_rden  <= w_rden_nxt;
      r_value <= w_value_nxt;
      r_index <= w_index_nxt;
      r_sbf   <= w_sbf_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_lat   <= w_lat_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // Next-state decode; abort outranks every other transition
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FETCH: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_lat_last) begin
          w_state_nxt = S_PRESENT;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_PRESENT: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_hold_last && !w_more) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_PRESENT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and counters
  always_comb begin
    w_addr_nxt  = r_addr;
    w_rden_nxt  = r_rden;
    w_value_nxt = r_value;
    w_index_nxt = r_index;
    w_sbf_nxt   = r_sbf;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_lat_nxt   = r_lat;
    w_hold_nxt  = r_hold;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_addr_nxt = '0;
          w_rden_nxt = 1'b1;
          w_busy_nxt = 1'b1;
          w_lat_nxt  = '0;
        end else begin
          w_lat_nxt  = r_lat;
        end
      end
      S_FETCH: begin
        if (bus.abort) begin
          w_sbf_nxt  = 1'b0;
          w_busy_nxt = 1'b0;
          w_rden_nxt = 1'b0;
          w_addr_nxt = '0;
        end else if (w_lat_last) begin
          w_value_nxt = bus.ram_q;
          w_index_nxt = '0;
          w_sbf_nxt   = 1'b1;
          w_addr_nxt  = w_first_addr;
          w_hold_nxt  = '0;
        end else begin
          w_lat_nxt   = r_lat + LAT_W'(1);
        end
      end
      S_PRESENT: begin
        if (bus.abort) begin
          w_sbf_nxt  = 1'b0;
          w_busy_nxt = 1'b0;
          w_rden_nxt = 1'b0;
          w_addr_nxt = '0;
        end else if (w_hold_last) begin
          if (w_more) begin
            w_value_nxt = bus.ram_q;
            w_index_nxt = r_index + 16'd1;
            w_addr_nxt  = w_next_addr;
            w_hold_nxt  = '0;
          end else begin
            w_sbf_nxt  = 1'b0;
            w_busy_nxt = 1'b0;
            w_done_nxt = 1'b1;
            w_rden_nxt = 1'b0;
          end
        end else begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end
      end
      default: begin
        w_sbf_nxt  = 1'b0;
        w_busy_nxt = 1'b0;
        w_rden_nxt = 1'b0;
      end
    endcase
  end

  assign bus.ram_address     = r_addr;
  assign bus.ram_rden        = r_rden;
  assign bus.sample_value    = r_value;
  assign bus.sample_index    = r_index;
  assign bus.startbeamformer = r_sbf;
  assign bus.busy            = r_busy;
  assign bus.done            = r_done;

endmodule

// File: tb/tb_sample_streamer.sv
// Self-checking bench for sample_streamer: an 8-sample and a 1-sample instance,
// each fed by a 2-cycle RAM and checked every cycle against a timing model.
`timescale 1ns/1ps
module tb_sample_streamer;

  localparam int          L        = 2;
  localparam int          H        = 4;
  localparam logic [31:0] RAM_BASE = 32'hA000_0000;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic cmp_en = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   done8_cnt = 0;
  int   d0;

  always #5 clk = ~clk;

  sample_streamer_if bus8();
  sample_streamer_if bus1();

  sample_streamer #(.NUM_SAMPLES(8), .RAM_LATENCY(2), .HOLD_CYCLES(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8));
  sample_streamer #(.NUM_SAMPLES(1), .RAM_LATENCY(2), .HOLD_CYCLES(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  // 2-cycle sample RAM: data word = base + address
  logic [15:0] r8_p1 = 16'd0, r8_p2 = 16'd0, r1_p1 = 16'd0, r1_p2 = 16'd0;
  always @(posedge clk) begin
    r8_p1 <= bus8.ram_address;
    r8_p2 <= r8_p1;
    r1_p1 <= bus1.ram_address;
    r1_p2 <= r1_p1;
  end
  assign bus8.ram_q = RAM_BASE + {16'd0, r8_p2};
  assign bus1.ram_q = RAM_BASE + {16'd0, r1_p2};

  // Reference model: expected outputs from the cycle count since the start edge
  for (genvar d = 0; d < 2; d++) begin : g_model
    localparam int N = (d == 0) ? 8 : 1;
    logic in_start, in_abort;
    assign in_start = (d == 0) ? bus8.start : bus1.start;
    assign in_abort = (d == 0) ? bus8.abort : bus1.abort;

    logic        m_active = 1'b0;
    int          m_j      = 0;
    logic [15:0] m_idx    = 16'd0;
    logic [31:0] m_val    = 32'd0;
    logic [15:0] m_addr   = 16'd0;
    logic        m_busy   = 1'b0;
    logic        m_sbf    = 1'b0;
    logic        m_done   = 1'b0;

    function automatic int frame_k(input int j);
      return (j - (L + 1)) / H;
    endfunction

    function automatic int next_addr(input int j);
      return (frame_k(j) + 1 < N) ? frame_k(j) + 1 : N - 1;
    endfunction

    always @(posedge clk) begin
      if (!rst_n) begin
        m_active <= 1'b0; m_j <= 0; m_idx <= 16'd0; m_val <= 32'd0;
        m_addr <= 16'd0; m_busy <= 1'b0; m_sbf <= 1'b0; m_done <= 1'b0;
      end else if (m_active && in_abort) begin
        m_active <= 1'b0; m_busy <= 1'b0; m_sbf <= 1'b0; m_addr <= 16'd0;
        m_done <= 1'b0;
      end else if (m_active) begin
        m_j <= m_j + 1;
        if (m_j + 1 >= L + 1 + N * H) begin
          m_active <= 1'b0; m_busy <= 1'b0; m_sbf <= 1'b0; m_done <= 1'b1;
        end else if (m_j + 1 >= L + 1) begin
          m_idx  <= 16'(frame_k(m_j + 1));
          m_val  <= RAM_BASE + 32'(frame_k(m_j + 1));
          m_addr <= 16'(next_addr(m_j + 1));
          m_sbf  <= 1'b1;
        end
      end else if (in_start && !in_abort) begin
        m_active <= 1'b1; m_j <= 0; m_busy <= 1'b1; m_addr <= 16'd0;
        m_done <= 1'b0;
      end else begin
        m_done <= 1'b0;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("sbf8",  {31'd0, bus8.startbeamformer}, {31'd0, g_model[0].m_sbf});
      check("busy8", {31'd0, bus8.busy},            {31'd0, g_model[0].m_busy});
      check("rden8", {31'd0, bus8.ram_rden},        {31'd0, g_model[0].m_busy});
      check("done8", {31'd0, bus8.done},            {31'd0, g_model[0].m_done});
      check("idx8",  {16'd0, bus8.sample_index},    {16'd0, g_model[0].m_idx});
      check("val8",  bus8.sample_value,             g_model[0].m_val);
      check("addr8", {16'd0, bus8.ram_address},     {16'd0, g_model[0].m_addr});
      check("sbf1",  {31'd0, bus1.startbeamformer}, {31'd0, g_model[1].m_sbf});
      check("busy1", {31'd0, bus1.busy},            {31'd0, g_model[1].m_busy});
      check("rden1", {31'd0, bus1.ram_rden},        {31'd0, g_model[1].m_busy});
      check("done1", {31'd0, bus1.done},            {31'd0, g_model[1].m_done});
      check("idx1",  {16'd0, bus1.sample_index},    {16'd0, g_model[1].m_idx});
      check("val1",  bus1.sample_value,             g_model[1].m_val);
      check("addr1", {16'd0, bus1.ram_address},     {16'd0, g_model[1].m_addr});
      if (bus8.done === 1'b1) done8_cnt++;
    end
  end

  task automatic check_zero8(input string tag);
    check({tag, "_sbf"},  {31'd0, bus8.startbeamformer}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus8.busy},            32'd0);
    check({tag, "_rden"}, {31'd0, bus8.ram_rden},        32'd0);
    check({tag, "_done"}, {31'd0, bus8.done},            32'd0);
    check({tag, "_idx"},  {16'd0, bus8.sample_index},    32'd0);
    check({tag, "_val"},  bus8.sample_value,             32'd0);
    check({tag, "_addr"}, {16'd0, bus8.ram_address},     32'd0);
  endtask

  initial begin
    bus8.start = 1'b0; bus8.abort = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    check_zero8("reset");
    rst_n = 1'b1;
    wait_n(4);
    check("idle_busy", {31'd0, bus8.busy}, 32'd0);

    // Single frame, with an ignored start at E0+10
    bus8.start = 1'b1; wait_n(1); bus8.start = 1'b0;
    check("f_busy_j0", {31'd0, bus8.busy}, 32'd1);
    check("f_sbf_j0",  {31'd0, bus8.startbeamformer}, 32'd0);
    wait_n(2);
    check("f_sbf_j2",  {31'd0, bus8.startbeamformer}, 32'd0);
    wait_n(1);
    check("f_sbf_j3",  {31'd0, bus8.startbeamformer}, 32'd1);
    check("f_idx_j3",  {16'd0, bus8.sample_index}, 32'd0);
    check("f_val_j3",  bus8.sample_value, 32'hA000_0000);
    wait_n(6); bus8.start = 1'b1; wait_n(1); bus8.start = 1'b0;
    wait_n(13);
    check("f_idx_j23", {16'd0, bus8.sample_index}, 32'd5);
    check("f_val_j23", bus8.sample_value, 32'hA000_0005);
    check("model_idx_j23", {16'd0, g_model[0].m_idx}, 32'd5);
    wait_n(11);
    check("f_done_j34", {31'd0, bus8.done}, 32'd0);
    check("f_busy_j34", {31'd0, bus8.busy}, 32'd1);
    check("f_idx_j34",  {16'd0, bus8.sample_index}, 32'd7);
    wait_n(1);
    check("f_done_j35", {31'd0, bus8.done}, 32'd1);
    check("f_busy_j35", {31'd0, bus8.busy}, 32'd0);
    check("model_done_j35", {31'd0, g_model[0].m_done}, 32'd1);

    // Back-to-back frame started in the done cycle, then aborted at E0+15
    bus8.start = 1'b1; wait_n(1); bus8.start = 1'b0;
    check("b2b_busy", {31'd0, bus8.busy}, 32'd1);
    wait_n(3);
    check("b2b_idx0", {16'd0, bus8.sample_index}, 32'd0);
    check("b2b_sbf",  {31'd0, bus8.startbeamformer}, 32'd1);
    wait_n(11); bus8.abort = 1'b1; wait_n(1); bus8.abort = 1'b0;
    check("abort_sbf",  {31'd0, bus8.startbeamformer}, 32'd0);
    check("abort_busy", {31'd0, bus8.busy}, 32'd0);
    check("abort_rden", {31'd0, bus8.ram_rden}, 32'd0);
    check("abort_addr", {16'd0, bus8.ram_address}, 32'd0);
    d0 = done8_cnt;
    wait_n(40);
    check("abort_no_done", 32'(done8_cnt), 32'(d0));

    // start together with abort in IDLE is dropped
    bus8.start = 1'b1; bus8.abort = 1'b1; wait_n(1);
    bus8.start = 1'b0; bus8.abort = 1'b0;
    check("start_abort_idle", {31'd0, bus8.busy}, 32'd0);

    // Fresh frame restarts at index 0, then reset mid-frame at E0+20
    bus8.start = 1'b1; wait_n(1); bus8.start = 1'b0;
    wait_n(3);
    check("restart_idx", {16'd0, bus8.sample_index}, 32'd0);
    check("restart_val", bus8.sample_value, 32'hA000_0000);
    wait_n(16); rst_n = 1'b0; wait_n(1);
    check_zero8("midrst");
    rst_n = 1'b1;
    d0 = done8_cnt;
    wait_n(40);
    check("midrst_no_done", 32'(done8_cnt), 32'(d0));

    // Single-sample frame
    bus1.start = 1'b1; wait_n(1); bus1.start = 1'b0;
    wait_n(3);
    check("n1_idx", {16'd0, bus1.sample_index}, 32'd0);
    check("n1_sbf", {31'd0, bus1.startbeamformer}, 32'd1);
    check("n1_val", bus1.sample_value, 32'hA000_0000);
    wait_n(3);
    check("n1_done_j6", {31'd0, bus1.done}, 32'd0);
    wait_n(1);
    check("n1_done_j7", {31'd0, bus1.done}, 32'd1);
    check("n1_busy_j7", {31'd0, bus1.busy}, 32'd0);
    check("n1_addr_j7", {16'd0, bus1.ram_address}, 32'd0);

    // Randomized start/abort/reset traffic on both instances
    for (int i = 0; i < 4000; i++) begin
      bus8.start = ($urandom_range(0, 9) == 0);
      bus8.abort = ($urandom_range(0, 99) == 0);
      bus1.start = ($urandom_range(0, 5) == 0);
      bus1.abort = ($urandom_range(0, 49) == 0);
      rst_n      = ($urandom_range(0, 999) != 0);
      wait_n(1);
    end
    bus8.start = 1'b0; bus8.abort = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0;
    rst_n = 1'b1;
    wait_n(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sample_streamer.md
# sample_streamer

Frame source for the delay beamformer. On `start`, reads `NUM_SAMPLES` words from the channel sample RAM in address order. Presents each word on `sample_value`, with its index on `sample_index`, for `HOLD_CYCLES` consecutive cycles. `startbeamformer` stays high for the whole frame. The beamformer therefore sees every index long enough to match it against its own delay-index ROM, which needs 3 cycles per read.

## Interface
- `NUM_SAMPLES`, default 4096: samples per frame. Legal range 1..65536.
- `RAM_LATENCY`, default 2: cycles from `ram_address` registered to `ram_q` valid.
- `HOLD_CYCLES`, default 4: cycles each index is presented. Must be ≥ `RAM_LATENCY`+1; checked by an elaboration-time assertion.
- `clk` in 1: single clock. All logic is rising-edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: begin a frame. Sampled in IDLE only.
- `abort` in 1: terminate the current frame. Synchronous.
- `ram_address` out 16: sample RAM read address.
- `ram_rden` out 1: sample RAM read enable.
- `ram_q` in 32: sample RAM read data.
- `sample_value` out 32: current sample, to the beamformer's `input_value`.
- `sample_index` out 16: current index, to the beamformer's `input_index`.
- `startbeamformer` out 1: frame active, to the beamformer's `startbeamformer`.
- `busy` out 1: high from the `start` edge until return to IDLE.
- `done` out 1: single-cycle pulse when a frame completes normally.

## Operation
- **Reset** (`rst_n`=0 at an edge): state IDLE. All outputs 0, all counters 0.
- **States:**
  - IDLE:
    - `start`=1 → FETCH. `ram_address`<=0, `ram_rden`<=1, `busy`<=1, latency counter cleared.
  - FETCH: waits `RAM_LATENCY`+1 edges for the first word.
    - Final edge: `sample_value`<=`ram_q`, `sample_index`<=0, `startbeamformer`<=1.
    - Same edge: `ram_address`<=1 (or held at 0 if `NUM_SAMPLES`=1), hold counter cleared → PRESENT.
  - PRESENT: hold counter counts 0..`HOLD_CYCLES`-1. On the edge where the counter equals `HOLD_CYCLES`-1:
    - If `sample_index` < `NUM_SAMPLES`-1: `sample_value`<=`ram_q`, `sample_index`<=`sample_index`+1.
    - Same case: `ram_address`<=min(`sample_index`+2, `NUM_SAMPLES`-1); counter cleared.
    - Else → IDLE: `startbeamformer`<=0, `busy`<=0, `done`<=1, `ram_rden`<=0.
- `ram_rden` is high for the entire frame. `ram_address` never exceeds `NUM_SAMPLES`-1.
- After a frame, `sample_value` and `sample_index` hold their last values. The beamformer ignores them because `startbeamformer`=0.
- `start` while `busy`=1 is ignored.
- **Abort** (any non-IDLE state, `abort`=1 at an edge): → IDLE. `startbeamformer`<=0, `busy`<=0, `ram_rden`<=0, `done` stays 0, `ram_address`<=0. Data outputs hold.
- `abort` and `start` together in IDLE: `abort` wins and `start` is dropped.
- **Arithmetic:** the index counter is 16-bit unsigned. No wrap is possible within legal `NUM_SAMPLES`. With `NUM_SAMPLES`=65536 the final index is 0xFFFF; the compare uses a 17-bit `NUM_SAMPLES`-1 constant.
- **Reset mid-frame:** identical to power-on reset. No `done`.

## Timing
- E0 is the edge where `start` is sampled in IDLE.
- Sample k is visible on the outputs after edge E0+`RAM_LATENCY`+1+k·`HOLD_CYCLES`, for exactly `HOLD_CYCLES` cycles.
- First-sample latency is `RAM_LATENCY`+1 cycles (3 with defaults).
- `done`=1 for the one cycle after edge E0+`RAM_LATENCY`+1+`NUM_SAMPLES`·`HOLD_CYCLES`. `busy` and `startbeamformer` fall at that same edge.
- A new `start` is accepted on the edge after `done` is asserted (back-to-back frames).
- The address for sample k+1 is issued at the edge sample k is presented. `HOLD_CYCLES` ≥ `RAM_LATENCY`+1 guarantees `ram_q` is valid at capture.
- `sample_value` and `sample_index` change only on presentation edges. No glitches between them.

## Test plan
Bench RAM model: 2-cycle latency, `ram_q` = 0xA000_0000 + address. Parameters `NUM_SAMPLES`=8, `HOLD_CYCLES`=4.

- **Reset:** hold `rst_n`=0 for 3 edges, then release → all outputs 0, state IDLE, no activity with `start`=0.
- **Single frame:** pulse `start` at E0.
  - `startbeamformer` rises after E0+3.
  - Index 0..7 each held 4 cycles, with `sample_value` = 0xA000_0000+index.
  - `done` pulses after E0+35; `busy` is high for cycles E0+1..E0+35.
- **Back-to-back:** assert `start` on the cycle `done`=1 → the second frame's index 0 appears 3 cycles later. No index is skipped or repeated beyond 4 cycles.
- **Start while busy:** pulse `start` again at E0+10 → no effect on addresses, indices, or `done` timing.
- **Abort:** assert `abort` at E0+15 (index 3) → `startbeamformer`, `busy`, and `ram_rden` are 0 after E0+15. `done` never asserts. The next `start` begins at index 0.
- **Edge and reset cases:**
  - `NUM_SAMPLES`=1: one index 0 held 4 cycles; `done` after E0+7.
  - `rst_n` low at E0+20: all outputs 0 after that edge, and no `done`.
